decoupled_rr_arbiter: RTL and testbench
=======================================

// Module: decoupled_rr_arbiter
// PURPOSE
//  Shares one decoupled (valid/ready/data) downstream channel among N_REQ upstream
//  decoupled requesters, e.g. several cores' R-reply paths onto one memory port.
//  Round-robin fairness; grant is locked across a multi-beat burst until the beat
//  flagged last completes. Presented beats stay stable until accepted (valid/ready rules).
// PARAMETERS
//  N_REQ   4   number of upstream requesters (2..16)
//  DATA_W  64  width of one beat's payload (packed decoupled_bit)
//  IDX_W   $clog2(N_REQ)  derived; do not override
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst        in   1             synchronous reset, active-high
//  in_valid   in   N_REQ         per-requester valid
//  in_ready   out  N_REQ         per-requester ready (one-hot or zero)
//  in_data    in   N_REQ*DATA_W  requester i payload at [i*DATA_W +: DATA_W]
//  in_last    in   N_REQ         per-requester last-beat-of-burst flag
//  out_valid  out  1             downstream valid
//  out_ready  in   1             downstream ready
//  out_data   out  DATA_W        downstream payload
//  out_last   out  1             downstream last flag
//  out_sel    out  IDX_W         index of requester currently driving out_*
// BEHAVIOUR
//  Interface: one clock (clk); reset synchronous, active-high (rst).
//  - State: fsm {IDLE, LOCKED}, rr_ptr[IDX_W], grant[IDX_W].
//  - Reset: fsm=IDLE, rr_ptr=0, grant=0; while rst=1: out_valid=0, in_ready=0, out_sel=0.
//  - IDLE: winner = first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//    out_* = requester winner (combinational, zero added latency); out_sel=winner.
//    No valid: out_valid=0, out_data/out_last don't-care, out_sel=rr_ptr.
//  - Handshake hs = out_valid & out_ready; in_ready[out_sel] = out_ready, others 0.
//  - IDLE transitions: hs & out_last -> IDLE, rr_ptr = winner+1 (mod N_REQ).
//    out_valid & !(hs & out_last) -> LOCKED, grant = winner (holds an unaccepted beat
//    stable and keeps the burst together).
//  - LOCKED: out_sel = grant regardless of other requesters; out_valid = in_valid[grant].
//    hs & out_last -> IDLE, rr_ptr = grant+1. Otherwise stay LOCKED.
//  - Pointer wrap: N_REQ-1 + 1 -> 0; non-power-of-two N_REQ must wrap explicitly.
//  - Simultaneous requests: only the winner sees ready; losers hold valid and wait.
//  - Requester dropping valid in LOCKED before hs is a protocol violation by upstream;
//    arbiter stays LOCKED (out_valid follows in_valid[grant]), no recovery needed.
//  - Reset mid-burst: abandons lock, returns to IDLE/rr_ptr=0 next cycle.
// CONFIGURATION
//  DECOUPLED_ARB_SLICE_EN defined: a full-throughput register slice (2-entry skid)
//  is inserted on out_*; arbitration unchanged but out_* appear 1 cycle after
//  acceptance into the slice; in_ready[i] = grant match & slice not full; out_sel
//  registered with the beat. Reset empties slice (out_valid=0).
//  Not defined: purely combinational out path as described above (0-cycle latency).
// TESTING (N_REQ=4, DATA_W=8, slice off unless stated)
//  1 rst=1 3 cycles, all in_valid=1 -> out_valid=0, in_ready=0; after release out_sel=0.
//  2 all 4 valid, single-beat (last=1), out_ready=1 4 cycles -> out_sel 0,1,2,3, data 0xA0..0xA3.
//  3 req1 3-beat burst (last on 3rd), req2 valid throughout -> sel=1 for 3 hs, then sel=2.
//  4 req3 valid, out_ready=0 5 cycles, req0 raises valid cycle 2 -> sel stays 3, data stable.
//  5 rr_ptr=3, req0+req3 valid -> req3 wins, next req0 (wrap); rst mid-burst -> IDLE, ptr=0.
//  6 DECOUPLED_ARB_SLICE_EN: back-to-back beats, out_ready=1 -> 1 beat/cycle, +1 cycle latency.

Source files
------------

// File: rtl/decoupled_rr_arbiter_if.sv
// Upstream requester channels plus the shared downstream decoupled channel.
// master = side driving requests and out_ready; slave = the arbiter.
interface decoupled_rr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 64
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        in_valid;
    logic [N_REQ-1:0]        in_ready;
    logic [N_REQ*DATA_W-1:0] in_data;
    logic [N_REQ-1:0]        in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic [IDX_W-1:0]        out_sel;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/decoupled_rr_arbiter.sv
// Round-robin arbiter sharing one decoupled channel; grant locks until the last beat.
// Optional DECOUPLED_ARB_SLICE_EN inserts a 2-entry skid slice on the output path.
module decoupled_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    decoupled_rr_arbiter_if.slave bus
);
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [0:0] {IDLE, LOCKED} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0] grant_reg, grant_next;

    logic [IDX_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_valid;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] sel;
    logic             arb_valid;
    logic [DATA_W-1:0] arb_data;
    logic             arb_last;
    logic             down_ready;
    logic             arb_hs;
    logic [N_REQ-1:0] in_ready_vec;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_REQ - 1))
            return '0;
        else
            return idx + IDX_W'(1);
    endfunction

    // Candidate k is requester (rr_ptr + k) mod N_REQ; explicit wrap for non-power-of-two N_REQ.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [SUM_W-1:0] sum;
            assign sum = {1'b0, rr_ptr_reg} + SUM_W'(gi);
            assign cand_idx[gi] = (sum >= SUM_W'(N_REQ)) ? IDX_W'(sum - SUM_W'(N_REQ))
                                                        : sum[IDX_W-1:0];
            assign cand_valid[gi] = bus.in_valid[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = rr_ptr_reg;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_valid[k])
                winner = cand_idx[k];
        end
    end

    always_comb begin
        sel = winner;
        if (state_reg == LOCKED)
            sel = grant_reg;
    end

    assign arb_valid = bus.in_valid[sel];
    assign arb_data  = bus.in_data[sel*DATA_W +: DATA_W];
    assign arb_last  = bus.in_last[sel];
    assign arb_hs    = arb_valid & down_ready & ~rst;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign in_ready_vec[gi] = ~rst & down_ready & (sel == IDX_W'(gi));
        end
    endgenerate
    assign bus.in_ready = in_ready_vec;

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        grant_next  = grant_reg;
        case (state_reg)
            IDLE: begin
                if (arb_hs && arb_last) begin
                    rr_ptr_next = next_idx(winner);
                end else if (arb_valid) begin
                    // Unaccepted beat or open burst: pin the grant so data stays stable.
                    state_next = LOCKED;
                    grant_next = winner;
                end
            end
            LOCKED: begin
                if (arb_hs && arb_last) begin
                    state_next  = IDLE;
                    rr_ptr_next = next_idx(grant_reg);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            grant_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            grant_reg  <= grant_next;
        end
    end

`ifdef DECOUPLED_ARB_SLICE_EN
    logic [DATA_W-1:0] slice_data_reg [2];
    logic              slice_last_reg [2];
    logic [IDX_W-1:0]  slice_sel_reg  [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic              slice_pop;

    // Ready depends only on occupancy, so the slice breaks the out_ready timing path.
    assign down_ready = (count_reg != 2'd2);
    assign slice_pop  = (count_reg != 2'd0) & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg       <= 1'b0;
            rd_ptr_reg       <= 1'b0;
            count_reg        <= 2'd0;
            slice_sel_reg[0] <= '0;
            slice_sel_reg[1] <= '0;
        end else begin
            if (arb_hs) begin
                slice_data_reg[wr_ptr_reg] <= arb_data;
                slice_last_reg[wr_ptr_reg] <= arb_last;
                slice_sel_reg[wr_ptr_reg]  <= sel;
                wr_ptr_reg                 <= ~wr_ptr_reg;
            end
            if (slice_pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, arb_hs} - {1'b0, slice_pop};
        end
    end

    assign bus.out_valid = (count_reg != 2'd0) & ~rst;
    assign bus.out_data  = slice_data_reg[rd_ptr_reg];
    assign bus.out_last  = slice_last_reg[rd_ptr_reg];
    assign bus.out_sel   = rst ? '0 : slice_sel_reg[rd_ptr_reg];
`else
    assign down_ready    = bus.out_ready;
    assign bus.out_valid = arb_valid & ~rst;
    assign bus.out_data  = arb_data;
    assign bus.out_last  = arb_last;
    assign bus.out_sel   = rst ? '0 : sel;
`endif

endmodule

// File: tb/tb_decoupled_rr_arbiter.sv
// Scoreboard bench for decoupled_rr_arbiter (N_REQ=4, DATA_W=8).
module tb_decoupled_rr_arbiter;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 2;

    typedef struct packed {
        logic [IDX_W-1:0]  sel;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decoupled_rr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();
    decoupled_rr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    beat_t exp_q[$];
    beat_t mon_got;
    beat_t mon_exp;
    int    checks = 0;
    int    passed = 0;

    // Every accepted downstream beat is matched against the next expected beat.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            mon_got = {bus.out_sel, bus.out_data, bus.out_last};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got sel=%0d data=%h last=%b, required no beat",
                         mon_got.sel, mon_got.data, mon_got.last);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL sb_beat: got sel=%0d data=%h last=%b, required sel=%0d data=%h last=%b",
                             mon_got.sel, mon_got.data, mon_got.last,
                             mon_exp.sel, mon_exp.data, mon_exp.last);
                else begin
                    passed++;
                    $display("beat ok sel=%0d data=%h last=%b", mon_got.sel, mon_got.data, mon_got.last);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [DATA_W-1:0] d, input logic l);
        bus.in_data[i*DATA_W +: DATA_W] = d;
        bus.in_last[i] = l;
    endtask

    task automatic push_exp(input int s, input logic [DATA_W-1:0] d, input logic l);
        beat_t b;
        b.sel  = IDX_W'(s);
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'hA0 + 8'(i), 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); else passed++;
            checks++; if (bus.in_ready !== 4'h0) $display("FAIL rst_in_ready: got %b required 0000", bus.in_ready); else passed++;
            next_cycle();
        end
        rst = 1'b0;
        bus.in_valid = 4'h0;
        @(negedge clk);
        checks++; if (bus.out_sel !== 2'd0) $display("FAIL rst_out_sel: got %0d required 0", bus.out_sel); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_idle_valid: got %b required 0", bus.out_valid); else passed++;
        next_cycle();
    endtask

`ifndef DECOUPLED_ARB_SLICE_EN
    task automatic test_round_robin();
        logic [N_REQ-1:0] want;
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 8'hA0 + 8'(i), 1'b1);
            push_exp(i, 8'hA0 + 8'(i), 1'b1);
        end
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            want = 4'(1 << i);
            @(negedge clk);
            checks++; if (bus.out_sel !== 2'(i)) $display("FAIL rr_sel: got %0d required %0d", bus.out_sel, i); else passed++;
            checks++; if (bus.in_ready !== want) $display("FAIL rr_ready: got %b required %b", bus.in_ready, want); else passed++;
            next_cycle();
        end
        bus.in_valid = 4'h0;
        checks++; if (exp_q.size() != 0) $display("FAIL rr_drain: got %0d pending required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_burst();
        bus.in_valid = 4'b0110;
        set_req(2, 8'h20, 1'b1);
        for (int b = 0; b < 3; b++) push_exp(1, 8'h11 + 8'(b), b == 2);
        push_exp(2, 8'h20, 1'b1);
        for (int b = 0; b < 3; b++) begin
            set_req(1, 8'h11 + 8'(b), b == 2);
            @(negedge clk);
            checks++; if (bus.out_sel !== 2'd1) $display("FAIL burst_sel: beat %0d got %0d required 1", b, bus.out_sel); else passed++;
            checks++; if (bus.in_ready !== 4'b0010) $display("FAIL burst_ready: beat %0d got %b required 0010", b, bus.in_ready); else passed++;
            next_cycle();
        end
        bus.in_valid = 4'b0100;
        @(negedge clk);
        checks++; if (bus.out_sel !== 2'd2) $display("FAIL burst_next_sel: got %0d required 2", bus.out_sel); else passed++;
        next_cycle();
        bus.in_valid = 4'h0;
        checks++; if (exp_q.size() != 0) $display("FAIL burst_drain: got %0d pending required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1000;
        set_req(3, 8'h33, 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                set_req(0, 8'h0C, 1'b1);
                bus.in_valid[0] = 1'b1;
            end
            @(negedge clk);
            checks++; if (bus.out_sel !== 2'd3) $display("FAIL hold_sel: cycle %0d got %0d required 3", c, bus.out_sel); else passed++;
            checks++; if (bus.out_data !== 8'h33) $display("FAIL hold_data: cycle %0d got %h required 33", c, bus.out_data); else passed++;
            checks++; if (bus.in_ready !== 4'h0) $display("FAIL hold_ready: cycle %0d got %b required 0000", c, bus.in_ready); else passed++;
            next_cycle();
        end
        push_exp(3, 8'h33, 1'b1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        next_cycle();
        bus.in_valid = 4'b0001;
        push_exp(0, 8'h0C, 1'b1);
        @(negedge clk);
        checks++; if (bus.out_sel !== 2'd0) $display("FAIL hold_after_sel: got %0d required 0", bus.out_sel); else passed++;
        next_cycle();
        bus.in_valid = 4'h0;
        checks++; if (exp_q.size() != 0) $display("FAIL hold_drain: got %0d pending required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_wrap_and_reset();
        // Requester 2 alone moves the pointer from 1 to 3.
        bus.in_valid = 4'b0100;
        set_req(2, 8'h22, 1'b1);
        push_exp(2, 8'h22, 1'b1);
        @(negedge clk);
        next_cycle();
        bus.in_valid = 4'b1001;
        set_req(3, 8'h3A, 1'b1);
        set_req(0, 8'h0A, 1'b1);
        push_exp(3, 8'h3A, 1'b1);
        push_exp(0, 8'h0A, 1'b1);
        @(negedge clk);
        checks++; if (bus.out_sel !== 2'd3) $display("FAIL wrap_first: got %0d required 3", bus.out_sel); else passed++;
        next_cycle();
        bus.in_valid = 4'b0001;
        @(negedge clk);
        checks++; if (bus.out_sel !== 2'd0) $display("FAIL wrap_second: got %0d required 0", bus.out_sel); else passed++;
        next_cycle();
        bus.in_valid = 4'b0010;
        set_req(1, 8'h51, 1'b0);
        push_exp(1, 8'h51, 1'b0);
        @(negedge clk);
        next_cycle();
        set_req(1, 8'h52, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid: got %b required 0", bus.out_valid); else passed++;
        next_cycle();
        rst = 1'b0;
        bus.in_valid = 4'h0;
        @(negedge clk);
        checks++; if (bus.out_sel !== 2'd0) $display("FAIL midrst_sel: got %0d required 0", bus.out_sel); else passed++;
        next_cycle();
        bus.in_valid = 4'b1001;
        set_req(0, 8'h0E, 1'b1);
        set_req(3, 8'h3E, 1'b1);
        push_exp(0, 8'h0E, 1'b1);
        @(negedge clk);
        checks++; if (bus.out_sel !== 2'd0) $display("FAIL midrst_ptr: got %0d required 0", bus.out_sel); else passed++;
        next_cycle();
        bus.in_valid = 4'h0;
        checks++; if (exp_q.size() != 0) $display("FAIL wrap_drain: got %0d pending required 0", exp_q.size()); else passed++;
    endtask
`else
    task automatic test_slice_back_to_back();
        logic want_valid;
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 8'hA0 + 8'(i), 1'b1);
            push_exp(i, 8'hA0 + 8'(i), 1'b1);
        end
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) bus.in_valid = 4'h0;
            want_valid = (c >= 1 && c <= 4);
            @(negedge clk);
            checks++; if (bus.out_valid !== want_valid) $display("FAIL slice_valid: cycle %0d got %b required %b", c, bus.out_valid, want_valid); else passed++;
            next_cycle();
        end
        checks++; if (exp_q.size() != 0) $display("FAIL slice_drain: got %0d pending required 0", exp_q.size()); else passed++;
    endtask
`endif

    initial begin
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b0;
        test_reset();
`ifndef DECOUPLED_ARB_SLICE_EN
        test_round_robin();
        test_burst();
        test_hold();
        test_wrap_and_reset();
`else
        test_slice_back_to_back();
`endif
        repeat (2) next_cycle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
